// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared constants and FSM encoding for the Connect-4 win detector
package connect4_pkg;

  localparam int BOARD_DIM = 4;
  localparam int NUM_LINES = 10;

  localparam logic [1:0]  NONE       = 2'b00;
  localparam logic [1:0]  P1         = 2'b01;
  localparam logic [1:0]  P2         = 2'b10;
  localparam logic [15:0] BOARD_FULL = 16'hFFFF;
  localparam logic [3:0]  LAST_LINE  = 4'(NUM_LINES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    OVER = 2'b10
  } state_t;

endpackage

// File: rtl/win_detector_if.sv
// rtl/win_detector_if.sv - move request and scan result signals between game logic and win detector
interface win_detector_if;

  logic        start;
  logic [15:0] in_gameboard;
  logic [15:0] in_players_cells;
  logic        busy;
  logic        done;
  logic [1:0]  winner;
  logic        draw;
  logic        game_over;
  logic [15:0] win_mask;

  modport master (
    output start, in_gameboard, in_players_cells,
    input  busy, done, winner, draw, game_over, win_mask
  );

  modport slave (
    input  start, in_gameboard, in_players_cells,
    output busy, done, winner, draw, game_over, win_mask
  );

endinterface

// File: rtl/win_detector_line_lut.sv
// rtl/win_detector_line_lut.sv - line index to 16-bit cell mask for the 4x4 board
module win_line_lut (
  input  logic [3:0]  line_idx,
  output logic [15:0] mask
);

  always_comb begin
    mask = 16'h0000;
    case (line_idx)
      4'd0: mask = 16'h000F;
      4'd1: mask = 16'h00F0;
      4'd2: mask = 16'h0F00;
      4'd3: mask = 16'hF000;
      4'd4: mask = 16'h1111;
      4'd5: mask = 16'h2222;
      4'd6: mask = 16'h4444;
      4'd7: mask = 16'h8888;
      4'd8: mask = 16'h8421;
      4'd9: mask = 16'h1248;
      default: mask = 16'h0000;
    endcase
  end

endmodule

// File: rtl/win_detector.sv
// rtl/win_detector.sv - snapshots the board on each accepted move and scans one win line per clock
module win_detector
  import connect4_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  win_detector_if.slave  bus
);

  state_t      state, state_n;
  logic [15:0] snap_gb, snap_gb_n;
  logic [15:0] snap_pc, snap_pc_n;
  logic [3:0]  line_idx, line_idx_n;
  logic        done_r, done_n;
  logic [1:0]  winner_r, winner_n;
  logic        draw_r, draw_n;
  logic        game_over_r, game_over_n;
  logic [15:0] win_mask_r, win_mask_n;

  logic [15:0] line_mask;
  logic        line_full;
  logic        line_p1;
  logic        line_p2;

  win_line_lut u_lut (
    .line_idx (line_idx),
    .mask     (line_mask)
  );

  // An all-zero mask would trivially match, so it is excluded explicitly.
  assign line_full = (line_mask != 16'h0000) && ((snap_gb & line_mask) == line_mask);
  assign line_p1   = line_full && ((snap_pc & line_mask) == 16'h0000);
  assign line_p2   = line_full && ((snap_pc & line_mask) == line_mask);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      snap_gb     <= '0;
      snap_pc     <= '0;
      line_idx    <= '0;
      done_r      <= 1'b0;
      winner_r    <= NONE;
      draw_r      <= 1'b0;
      game_over_r <= 1'b0;
      win_mask_r  <= '0;
    end else begin
      state       <= state_n;
      snap_gb     <= snap_gb_n;
      snap_pc     <= snap_pc_n;
      line_idx    <= line_idx_n;
      done_r      <= done_n;
      winner_r    <= winner_n;
      draw_r      <= draw_n;
      game_over_r <= game_over_n;
      win_mask_r  <= win_mask_n;
    end
  end

  always_comb begin
    state_n     = state;
    snap_gb_n   = snap_gb;
    snap_pc_n   = snap_pc;
    line_idx_n  = line_idx;
    done_n      = 1'b0;
    winner_n    = winner_r;
    draw_n      = draw_r;
    game_over_n = game_over_r;
    win_mask_n  = win_mask_r;

    case (state)
      IDLE: begin
        if (bus.start) begin
          snap_gb_n  = bus.in_gameboard;
          snap_pc_n  = bus.in_players_cells;
          line_idx_n = 4'd0;
          state_n    = SCAN;
        end
      end
      SCAN: begin
        if (line_p1 || line_p2) begin
          winner_n    = line_p1 ? P1 : P2;
          win_mask_n  = line_mask;
          game_over_n = 1'b1;
          done_n      = 1'b1;
          state_n     = OVER;
        end else if (line_idx == LAST_LINE) begin
          done_n = 1'b1;
          if (snap_gb == BOARD_FULL) begin
            draw_n      = 1'b1;
            game_over_n = 1'b1;
            state_n     = OVER;
          end else begin
            state_n = IDLE;
          end
        end else begin
          line_idx_n = line_idx + 4'd1;
        end
      end
      OVER: begin
        state_n = OVER;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy      = (state == SCAN);
  assign bus.done      = done_r;
  assign bus.winner    = winner_r;
  assign bus.draw      = draw_r;
  assign bus.game_over = game_over_r;
  assign bus.win_mask  = win_mask_r;

endmodule
